// File: rtl/risc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// risc_fetch_pkg
// Shared definitions for the instruction fetch stage: branch-select
// encodings driven by the decoder, the NOP instruction word, and the fetch
// state enumeration.
//
// Configuration macro: PREFETCH_EN adds the DROP state, which is used to
// absorb an abandoned prefetch response after a redirect.
// ---------------------------------------------------------------------------
package risc_fetch_pkg;

  // Branch-select encodings for the consumed instruction
  localparam logic [1:0] BS_NEXT = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JREG = 2'b10;
  localparam logic [1:0] BS_JUMP = 2'b11;

  // All-zero instruction word decodes as NOP
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_START = 2'd0,
    FETCH       = 2'd1,
    HOLD        = 2'd2
`ifdef PREFETCH_EN
    ,
    DROP        = 2'd3
`endif
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC selection for the fetch stage.
//
// Ports:
//   i_BS          branch select (NEXT / COND / JREG / JUMP)
//   i_PS          conditional-branch polarity
//   i_Z           zero flag of the consumed instruction
//   i_PC_1        address of the current instruction plus one
//   i_BRANCH_OFS  two's-complement PC-relative offset
//   i_RA_DATA     jump-register target
//   o_NEXT_PC     selected next fetch address
// ---------------------------------------------------------------------------
module next_pc_sel
  import risc_fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      i_BS,
  input  logic            i_PS,
  input  logic            i_Z,
  input  logic [PC_W-1:0] i_PC_1,
  input  logic [PC_W-1:0] i_BRANCH_OFS,
  input  logic [PC_W-1:0] i_RA_DATA,
  output logic [PC_W-1:0] o_NEXT_PC
);

  logic [PC_W-1:0] w_target;

  // Relative target; the sum wraps silently modulo 2^PC_W, and a negative
  // offset works because it is already two's complement at full width
  assign w_target = i_PC_1 + i_BRANCH_OFS;

  // Select the next fetch address from the decoder's branch controls
  always_comb begin
    o_NEXT_PC = i_PC_1;
    case (i_BS)
      BS_NEXT: o_NEXT_PC = i_PC_1;
      BS_COND: if (i_Z ^ i_PS) o_NEXT_PC = w_target;
      BS_JREG: o_NEXT_PC = i_RA_DATA;
      BS_JUMP: o_NEXT_PC = w_target;
      default: o_NEXT_PC = i_PC_1;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, runs the single-outstanding instruction-memory
// handshake, and presents the current instruction word to the decoder.
//
// Ports:
//   i_CLK, i_RESET            clock, synchronous active-high reset
//   i_STALL                   downstream not ready (consume = IR_VALID & !STALL)
//   i_BS, i_PS, i_Z           branch controls for the consumed instruction
//   i_BRANCH_OFS, i_RA_DATA   relative offset and jump-register target
//   o_IMEM_REQ, o_IMEM_ADDR   registered fetch request / address
//   i_IMEM_VALID, i_IMEM_RDATA  memory response
//   o_IR_instruction, o_IR_VALID, o_PC_1  registered instruction to decoder
//
// Configuration macro: PREFETCH_EN enables a one-entry prefetch buffer that
// is filled from PC_1 while the current instruction is held, giving one
// instruction per cycle on sequential code.
// ---------------------------------------------------------------------------
module instruction_fetch
  import risc_fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_CLK,
  input  logic            i_RESET,
  input  logic            i_STALL,
  input  logic [1:0]      i_BS,
  input  logic            i_PS,
  input  logic            i_Z,
  input  logic [PC_W-1:0] i_BRANCH_OFS,
  input  logic [PC_W-1:0] i_RA_DATA,
  output logic            o_IMEM_REQ,
  output logic [PC_W-1:0] o_IMEM_ADDR,
  input  logic            i_IMEM_VALID,
  input  logic [31:0]     i_IMEM_RDATA,
  output logic [31:0]     o_IR_instruction,
  output logic            o_IR_VALID,
  output logic [PC_W-1:0] o_PC_1
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t    r_state, w_stateNext;
  logic [31:0]     r_ir, w_irNext;
  logic            r_irValid, w_irValidNext;
  logic [PC_W-1:0] r_pc1, w_pc1Next;
  logic            r_req, w_reqNext;
  logic [PC_W-1:0] r_addr, w_addrNext;
  logic [PC_W-1:0] r_pc, w_pcNext;

  logic [PC_W-1:0] w_nextPc;
  logic            w_consume;
  logic            w_capture;

`ifdef PREFETCH_EN
  logic [31:0]     r_buf, w_bufNext;
  logic            r_bufValid, w_bufValidNext;
  logic            w_redirect;
`endif

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_nextPcSel (
    .i_BS         (i_BS),
    .i_PS         (i_PS),
    .i_Z          (i_Z),
    .i_PC_1       (r_pc1),
    .i_BRANCH_OFS (i_BRANCH_OFS),
    .i_RA_DATA    (i_RA_DATA),
    .o_NEXT_PC    (w_nextPc)
  );

  // A response only counts while our own request is up; this also makes a
  // late response after reset harmless
  assign w_consume = r_irValid & ~i_STALL;
  assign w_capture = r_req & i_IMEM_VALID;

`ifdef PREFETCH_EN
  assign w_redirect = (w_nextPc != r_pc1);
`endif

  // Next-state and next-register computation for the fetch FSM; every
  // registered output is produced here so nothing reaches an output port
  // combinationally from an input
  always_comb begin
    w_stateNext   = r_state;
    w_irNext      = r_ir;
    w_irValidNext = r_irValid;
    w_pc1Next     = r_pc1;
    w_reqNext     = r_req;
    w_addrNext    = r_addr;
    w_pcNext      = r_pc;
`ifdef PREFETCH_EN
    w_bufNext      = r_buf;
    w_bufValidNext = r_bufValid;
`endif

    case (r_state)
      FETCH_START: begin
        w_reqNext   = 1'b1;
        w_addrNext  = r_pc;
        w_stateNext = FETCH;
      end

      FETCH: begin
        if (w_capture) begin
          w_irNext      = i_IMEM_RDATA;
          w_irValidNext = 1'b1;
          w_pc1Next     = r_addr + PC_ONE;
          w_stateNext   = HOLD;
`ifdef PREFETCH_EN
          // Start prefetching the sequential successor straight away
          w_reqNext  = 1'b1;
          w_addrNext = r_addr + PC_ONE;
`else
          w_reqNext  = 1'b0;
`endif
        end
      end

      HOLD: begin
        if (w_consume) begin
          w_pcNext      = w_nextPc;
          w_irValidNext = 1'b0;
`ifdef PREFETCH_EN
          w_bufValidNext = 1'b0;
          if (!w_redirect && (r_bufValid || w_capture)) begin
            // Sequential hit: buffered word, or the response landing on
            // this very edge, becomes the new IR; prefetch its successor
            w_irNext      = r_bufValid ? r_buf : i_IMEM_RDATA;
            w_irValidNext = 1'b1;
            w_pc1Next     = r_pc1 + PC_ONE;
            w_reqNext     = 1'b1;
            w_addrNext    = r_pc1 + PC_ONE;
            w_stateNext   = HOLD;
          end else if (!w_redirect && r_req) begin
            // Sequential, prefetch still in flight: it is the right address
            w_stateNext = FETCH;
          end else if (w_redirect && r_req && !i_IMEM_VALID) begin
            // Wrong-path request cannot be withdrawn; drain it first
            w_stateNext = DROP;
          end else begin
            w_reqNext   = 1'b0;
            w_stateNext = FETCH_START;
          end
`else
          w_stateNext = FETCH_START;
`endif
        end
`ifdef PREFETCH_EN
        else if (w_capture) begin
          w_bufNext      = i_IMEM_RDATA;
          w_bufValidNext = 1'b1;
          w_reqNext      = 1'b0;
        end else if (!r_req && !r_bufValid) begin
          w_reqNext  = 1'b1;
          w_addrNext = r_pc1;
        end
`endif
      end

`ifdef PREFETCH_EN
      DROP: begin
        if (w_capture) begin
          w_reqNext   = 1'b0;
          w_stateNext = FETCH_START;
        end
      end
`endif

      default: begin
        w_reqNext   = 1'b0;
        w_stateNext = FETCH_START;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state   <= FETCH_START;
      r_ir      <= NOP_WORD;
      r_irValid <= 1'b0;
      r_pc1     <= RESET_PC + PC_ONE;
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
      r_pc      <= RESET_PC;
`ifdef PREFETCH_EN
      r_buf      <= NOP_WORD;
      r_bufValid <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_ir      <= w_irNext;
      r_irValid <= w_irValidNext;
      r_pc1     <= w_pc1Next;
      r_req     <= w_reqNext;
      r_addr    <= w_addrNext;
      r_pc      <= w_pcNext;
`ifdef PREFETCH_EN
      r_buf      <= w_bufNext;
      r_bufValid <= w_bufValidNext;
`endif
    end
  end

  assign o_IMEM_REQ       = r_req;
  assign o_IMEM_ADDR      = r_addr;
  assign o_IR_instruction = r_ir;
  assign o_IR_VALID       = r_irValid;
  assign o_PC_1           = r_pc1;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a latency-configurable
// instruction memory model whose word at address a is {8'hA5, a[23:0]}.
// Honours PREFETCH_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;
  import risc_fetch_pkg::*;

  logic        clock;
  logic        reset;
  logic        stall;
  logic [1:0]  bs;
  logic        ps;
  logic        z;
  logic [31:0] branchOfs;
  logic [31:0] raData;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic [31:0] irInstruction;
  logic        irValid;
  logic [31:0] pc1;

  int vectorCount = 0;
  int missCount   = 0;
  int memLat      = 1;
  int memCnt      = 0;

  instruction_fetch #(
    .PC_W     (32),
    .RESET_PC (32'h0)
  ) dut (
    .i_CLK            (clock),
    .i_RESET          (reset),
    .i_STALL          (stall),
    .i_BS             (bs),
    .i_PS             (ps),
    .i_Z              (z),
    .i_BRANCH_OFS     (branchOfs),
    .i_RA_DATA        (raData),
    .o_IMEM_REQ       (imemReq),
    .o_IMEM_ADDR      (imemAddr),
    .i_IMEM_VALID     (imemValid),
    .i_IMEM_RDATA     (imemRdata),
    .o_IR_instruction (irInstruction),
    .o_IR_VALID       (irValid),
    .o_PC_1           (pc1)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Memory answers after memLat request cycles
  assign imemValid = imemReq && (memCnt >= memLat - 1);
  assign imemRdata = memWord(imemAddr);

  always @(posedge clock) begin
    if (!imemReq || imemValid) memCnt <= 0;
    else                       memCnt <= memCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitIrValid(input int maxCycles, input string tag);
    int n = 0;
    while (!irValid && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'b0, irValid}, 32'h1);
  endtask

  // Consume the held instruction with the given branch controls, then check
  // the redirected fetch with zero-wait memory and prefetch off
  task automatic applyStimulus(input logic [1:0] vBs, input logic vPs,
                               input logic vZ, input logic [31:0] vOfs,
                               input logic [31:0] vRa, input logic [31:0] expAddr,
                               input string tag);
    bs = vBs; ps = vPs; z = vZ; branchOfs = vOfs; raData = vRa;
    stall = 1'b0;
    tick();
    stall = 1'b1;
    bs = ~vBs; ps = ~vPs; z = ~vZ; branchOfs = 32'h0000_DEAD; raData = 32'h0000_BEEF;
    checkOutput({tag, "/validDrop"}, {31'b0, irValid}, 32'h0);
    tick();
    checkOutput({tag, "/req"}, {31'b0, imemReq}, 32'h1);
    checkOutput({tag, "/addr"}, imemAddr, expAddr);
    tick();
    checkOutput({tag, "/valid"}, {31'b0, irValid}, 32'h1);
    checkOutput({tag, "/ir"}, irInstruction, memWord(expAddr));
    checkOutput({tag, "/pc1"}, pc1, expAddr + 32'h1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; bs = BS_NEXT; ps = 1'b0; z = 1'b0;
    branchOfs = 32'h0; raData = 32'h0; memLat = 1;
    tick();
    tick();
    checkOutput("rst/ir", irInstruction, NOP_WORD);
    checkOutput("rst/valid", {31'b0, irValid}, 32'h0);
    checkOutput("rst/req", {31'b0, imemReq}, 32'h0);
    checkOutput("rst/addr", imemAddr, 32'h0);
    checkOutput("rst/pc1", pc1, 32'h1);

    reset = 1'b0;
    tick();
    checkOutput("first/req", {31'b0, imemReq}, 32'h1);
    checkOutput("first/addr", imemAddr, 32'h0);
    tick();
    checkOutput("first/valid", {31'b0, irValid}, 32'h1);
    checkOutput("first/ir", irInstruction, memWord(32'h0));
    checkOutput("first/pc1", pc1, 32'h1);

`ifdef PREFETCH_EN
    // Sequential streaming at one instruction per cycle
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("stream%0d/valid", k), {31'b0, irValid}, 32'h1);
      checkOutput($sformatf("stream%0d/ir", k), irInstruction, memWord(k));
      tick();
    end
    stall = 1'b1;

    // Redirect while the prefetch is still outstanding on slow memory
    memLat = 3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    waitIrValid(20, "pfRedir/firstValid");
    checkOutput("pfRedir/firstIr", irInstruction, memWord(32'h0));
    checkOutput("pfRedir/pending", {31'b0, imemReq}, 32'h1);
    bs = BS_JREG; raData = 32'h20; stall = 1'b0;
    tick();
    stall = 1'b1; raData = 32'h0; bs = BS_NEXT;
    checkOutput("pfRedir/validDrop", {31'b0, irValid}, 32'h0);
    waitIrValid(20, "pfRedir/valid");
    checkOutput("pfRedir/ir", irInstruction, memWord(32'h20));
    checkOutput("pfRedir/pc1", pc1, 32'h21);
`else
    // IR held steady under stall, no speculative request
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("stall%0d/ir", k), irInstruction, memWord(32'h0));
      checkOutput($sformatf("stall%0d/pc1", k), pc1, 32'h1);
      checkOutput($sformatf("stall%0d/req", k), {31'b0, imemReq}, 32'h0);
    end

    applyStimulus(BS_JREG, 1'b0, 1'b0, 32'h0,         32'h0000_000A, 32'h0000_000A, "jmrTo10");
    applyStimulus(BS_COND, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0000_0007, "bzTaken");
    applyStimulus(BS_JREG, 1'b0, 1'b0, 32'h0,         32'h0000_000A, 32'h0000_000A, "jmrBack10");
    applyStimulus(BS_COND, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_000B, "bzNotTaken");
    applyStimulus(BS_COND, 1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'h0000_0011, "bnzTaken");
    applyStimulus(BS_COND, 1'b1, 1'b1, 32'h0000_0005, 32'h0,         32'h0000_0012, "bnzNotTaken");
    applyStimulus(BS_JREG, 1'b0, 1'b0, 32'h0,         32'h0000_0040, 32'h0000_0040, "jmr40");
    applyStimulus(BS_NEXT, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0041, "seq41");
    applyStimulus(BS_JREG, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFE, 32'hFFFF_FFFE, "jmrTop");
    applyStimulus(BS_JUMP, 1'b0, 1'b0, 32'h0000_0002, 32'h0,         32'h0000_0001, "jmpWrap");
    applyStimulus(BS_NEXT, 1'b1, 1'b1, 32'h0,         32'h0,         32'h0000_0002, "seq2");
`endif

    // Reset landing while a slow fetch is outstanding
    memLat = 3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("midRst/reqBefore", {31'b0, imemReq}, 32'h1);
    reset = 1'b1;
    tick();
    checkOutput("midRst/valid", {31'b0, irValid}, 32'h0);
    checkOutput("midRst/req", {31'b0, imemReq}, 32'h0);
    checkOutput("midRst/addr", imemAddr, 32'h0);
    checkOutput("midRst/ir", irInstruction, NOP_WORD);
    reset = 1'b0;
    tick();
    checkOutput("midRst/restartReq", {31'b0, imemReq}, 32'h1);
    checkOutput("midRst/restartAddr", imemAddr, 32'h0);
    waitIrValid(10, "midRst/restartValid");
    checkOutput("midRst/restartIr", irInstruction, memWord(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
